// File: rtl/vram_write_port.sv
// CPU store path into the 16-bit VRAM: buffers byte/half/word stores in a FIFO, applies
// mirroring, byte duplication, OBJ byte-drop and word split, and writes one halfword per grant.
module vram_write_port #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [16:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_data,
  input  logic [15:0] dispcnt,
  input  logic        vram_grant,
  output logic        vram_wr,
  output logic [15:0] vram_addr,
  output logic [15:0] vram_wdata,
  output logic        busy,
  output logic        dropped
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI} state_t;

  logic [16:0] fifo_addr_q [FIFO_DEPTH];
  logic [16:0] fifo_addr_d [FIFO_DEPTH];
  logic [1:0]  fifo_size_q [FIFO_DEPTH];
  logic [1:0]  fifo_size_d [FIFO_DEPTH];
  logic [31:0] fifo_data_q [FIFO_DEPTH];
  logic [31:0] fifo_data_d [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  state_t      state_q, state_d;
  logic        vram_wr_q, vram_wr_d;
  logic [15:0] vram_addr_q, vram_addr_d;
  logic [15:0] vram_wdata_q, vram_wdata_d;
  logic [15:0] hi_data_q, hi_data_d;
  logic        is_word_q, is_word_d;
  logic        dropped_q, dropped_d;

  logic        full, push, pop;
  logic [16:0] push_eff;
  logic [16:0] head_addr;
  logic [1:0]  head_size;
  logic [31:0] head_data;
  logic [16:0] bg_limit;

  assign full      = (count_q == CNT_FULL);
  assign req_ready = !full;
  assign push      = req_valid && !full;
  assign pop       = (state_q == IDLE) && (count_q != '0);

  // Upper 32K of the region mirrors the OBJ bank, so fold it down before storing.
  assign push_eff  = (req_addr >= 17'h18000) ? (req_addr - 17'h08000) : req_addr;

  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_size = fifo_size_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];
  assign bg_limit  = (dispcnt[2:0] < 3'd3) ? 17'h10000 : 17'h14000;

  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_size_d = fifo_size_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_addr_d[wr_ptr_q] = push_eff;
      fifo_size_d[wr_ptr_q] = req_size;
      fifo_data_d[wr_ptr_q] = req_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    vram_wr_d    = vram_wr_q;
    vram_addr_d  = vram_addr_q;
    vram_wdata_d = vram_wdata_q;
    hi_data_d    = hi_data_q;
    is_word_d    = is_word_q;
    dropped_d    = 1'b0;
    case (state_q)
      IDLE: begin
        vram_wr_d = 1'b0;
        if (pop) begin
          if (head_size == 2'd0 && head_addr >= bg_limit) begin
            dropped_d = 1'b1;
          end else begin
            state_d   = WR_LO;
            vram_wr_d = 1'b1;
            hi_data_d = head_data[31:16];
            is_word_d = (head_size >= 2'd2);
            case (head_size)
              2'd0: begin
                vram_addr_d  = head_addr[16:1];
                vram_wdata_d = {head_data[7:0], head_data[7:0]};
              end
              2'd1: begin
                vram_addr_d  = head_addr[16:1];
                vram_wdata_d = head_data[15:0];
              end
              default: begin
                vram_addr_d  = {head_addr[16:2], 1'b0};
                vram_wdata_d = head_data[15:0];
              end
            endcase
          end
        end
      end
      WR_LO: begin
        if (vram_wr_q && vram_grant) begin
          if (is_word_q) begin
            state_d      = WR_HI;
            vram_addr_d  = vram_addr_q + 16'd1;
            vram_wdata_d = hi_data_q;
          end else begin
            state_d   = IDLE;
            vram_wr_d = 1'b0;
          end
        end
      end
      WR_HI: begin
        if (vram_wr_q && vram_grant) begin
          state_d   = IDLE;
          vram_wr_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        vram_wr_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      vram_wr_q    <= 1'b0;
      vram_addr_q  <= '0;
      vram_wdata_q <= '0;
      hi_data_q    <= '0;
      is_word_q    <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      state_q      <= state_d;
      vram_wr_q    <= vram_wr_d;
      vram_addr_q  <= vram_addr_d;
      vram_wdata_q <= vram_wdata_d;
      hi_data_q    <= hi_data_d;
      is_word_q    <= is_word_d;
      dropped_q    <= dropped_d;
    end
  end

  // Storage needs no reset: the pointers and count alone decide what is valid.
  always_ff @(posedge clk) begin
    fifo_addr_q <= fifo_addr_d;
    fifo_size_q <= fifo_size_d;
    fifo_data_q <= fifo_data_d;
  end

  assign vram_wr    = vram_wr_q;
  assign vram_addr  = vram_addr_q;
  assign vram_wdata = vram_wdata_q;
  assign dropped    = dropped_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_vram_write_port.sv
// Directed self-checking bench for vram_write_port: logs completed writes and drop pulses,
// then compares them against hand-computed expectations.
module tb_vram_write_port;

  logic        clk = 1'b0;
  logic        clrn;
  logic        req_valid;
  logic        req_ready;
  logic [16:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_data;
  logic [15:0] dispcnt;
  logic        vram_grant;
  logic        vram_wr;
  logic [15:0] vram_addr;
  logic [15:0] vram_wdata;
  logic        busy;
  logic        dropped;

  int n_checks = 0;
  int n_fail   = 0;
  int drop_cnt = 0;
  int drop_base;
  logic [15:0] wa [$];
  logic [15:0] wd [$];
  logic [15:0] hold_addr, hold_data;

  vram_write_port #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .clrn(clrn), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_data(req_data), .dispcnt(dispcnt),
    .vram_grant(vram_grant), .vram_wr(vram_wr), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  // Record every completed halfword write and every drop pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (vram_wr && vram_grant) begin
      wa.push_back(vram_addr);
      wd.push_back(vram_wdata);
    end
    if (dropped) drop_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [16:0] a, input logic [1:0] s, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_data  = d;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("push_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic checkLog(input string tag, input int idx, input logic [15:0] a, input logic [15:0] d);
    if (idx < wa.size()) begin
      checkOutput({tag, "_addr"}, 32'(wa[idx]), 32'(a));
      checkOutput({tag, "_data"}, 32'(wd[idx]), 32'(d));
    end else begin
      checkOutput({tag, "_missing"}, 32'(wa.size()), 32'(idx + 1));
    end
  endtask

  task automatic setGrant(input logic g);
    @(posedge clk);
    #1 vram_grant = g;
  endtask

  task automatic clearLog();
    wa.delete();
    wd.delete();
    drop_base = drop_cnt;
  endtask

  initial begin
    clrn = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_data = '0;
    dispcnt = '0; vram_grant = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_vram_wr", 32'(vram_wr), 32'd0);
    checkOutput("rst_addr", 32'(vram_addr), 32'd0);
    checkOutput("rst_wdata", 32'(vram_wdata), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dropped", 32'(dropped), 32'd0);
    @(posedge clk);
    #1 clrn = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);

    // Single half store, including the two-cycle accept-to-write latency.
    setGrant(1'b1);
    clearLog();
    applyStimulus(17'h00010, 2'd1, 32'h0000BEEF);
    @(negedge clk);
    checkOutput("lat_n1_wr", 32'(vram_wr), 32'd0);
    @(negedge clk);
    checkOutput("lat_n2_wr", 32'(vram_wr), 32'd1);
    waitIdle("half");
    checkOutput("half_count", 32'(wa.size()), 32'd1);
    checkLog("half", 0, 16'h0008, 16'hBEEF);
    checkOutput("half_busy", 32'(busy), 32'd0);

    // Word split into low then high halfword.
    clearLog();
    applyStimulus(17'h00104, 2'd2, 32'h12345678);
    waitIdle("word");
    checkOutput("word_count", 32'(wa.size()), 32'd2);
    checkLog("word_lo", 0, 16'h0082, 16'h5678);
    checkLog("word_hi", 1, 16'h0083, 16'h1234);

    // Byte duplication in bitmap mode.
    dispcnt = 16'h0003;
    clearLog();
    applyStimulus(17'h00021, 2'd0, 32'h000000AB);
    waitIdle("byte");
    checkOutput("byte_count", 32'(wa.size()), 32'd1);
    checkLog("byte", 0, 16'h0010, 16'hABAB);

    // Tile mode: byte at the OBJ boundary is dropped.
    dispcnt = 16'h0000;
    clearLog();
    applyStimulus(17'h10000, 2'd0, 32'h000000CD);
    waitIdle("drop");
    checkOutput("drop_pulses", 32'(drop_cnt - drop_base), 32'd1);
    checkOutput("drop_writes", 32'(wa.size()), 32'd0);

    // Bitmap mode: last BG byte still writes.
    dispcnt = 16'h0003;
    clearLog();
    applyStimulus(17'h13FFF, 2'd0, 32'h0000005A);
    waitIdle("bmp_edge");
    checkOutput("bmp_edge_drops", 32'(drop_cnt - drop_base), 32'd0);
    checkLog("bmp_edge", 0, 16'h9FFF, 16'h5A5A);

    // Mirrored half, then misaligned half, in order.
    dispcnt = 16'h0000;
    clearLog();
    applyStimulus(17'h18002, 2'd1, 32'h00001111);
    applyStimulus(17'h00003, 2'd1, 32'h00002222);
    waitIdle("mirror");
    checkOutput("mirror_count", 32'(wa.size()), 32'd2);
    checkLog("mirror", 0, 16'h8001, 16'h1111);
    checkLog("odd_half", 1, 16'h0001, 16'h2222);

    // Grant held low: one store sits in WR_LO, four fill the FIFO, so ready drops after five accepts.
    setGrant(1'b0);
    clearLog();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(17'h00200 + 17'(2 * i), 2'd1, 32'h0000A000 + 32'(i));
    end
    @(negedge clk);
    checkOutput("full_ready", 32'(req_ready), 32'd0);
    checkOutput("full_wr", 32'(vram_wr), 32'd1);
    hold_addr = vram_addr;
    hold_data = vram_wdata;
    req_valid = 1'b1;
    req_addr  = 17'h003F0;
    req_size  = 2'd1;
    req_data  = 32'h0000FFFF;
    repeat (4) @(negedge clk);
    checkOutput("stall_ready", 32'(req_ready), 32'd0);
    checkOutput("stall_wr", 32'(vram_wr), 32'd1);
    checkOutput("stall_addr", 32'(vram_addr), 32'(hold_addr));
    checkOutput("stall_data", 32'(vram_wdata), 32'(hold_data));
    checkOutput("stall_addr_val", 32'(vram_addr), 32'h0100);
    req_valid = 1'b0;
    setGrant(1'b1);
    waitIdle("drain");
    checkOutput("drain_count", 32'(wa.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      checkLog($sformatf("drain%0d", i), i, 16'h0100 + 16'(i), 16'hA000 + 16'(i));
    end

    // Reset while a write is pending with three entries queued.
    setGrant(1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(17'h00300 + 17'(2 * i), 2'd1, 32'h0000C000 + 32'(i));
    end
    @(negedge clk);
    checkOutput("pre_rst_wr", 32'(vram_wr), 32'd1);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 clrn = 1'b0;
    @(posedge clk);
    #1 clrn = 1'b1;
    vram_grant = 1'b1;
    clearLog();
    @(negedge clk);
    checkOutput("post_rst_wr", 32'(vram_wr), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("post_rst_writes", 32'(wa.size()), 32'd0);
    checkOutput("post_rst_busy_late", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
